// File: rtl/bcd_timer_pkg.sv
// rtl/bcd_timer_pkg.sv - shared types, constants and BCD saturation helper for the countdown timer
package bcd_timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    function automatic logic [DIGIT_W-1:0] bcd_sat(input logic [DIGIT_W-1:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// rtl/bcd_digit_down.sv - one BCD digit of the down-counter with 0->9 wrap and borrow chain
module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] ld_val,
    input  logic               dec_en,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out
);

    assign borrow_out = (digit == '0) && borrow_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
        end else if (ld) begin
            digit <= ld_val;
        end else if (dec_en && borrow_in) begin
            digit <= (digit == '0) ? BCD_MAX : digit - 1'b1;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - multi-digit BCD countdown timer; optional BCD_TIMER_AUTO_RELOAD_EN
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    input  logic                    start,
    input  logic                    pause,
    output logic [DIGIT_W*DIGITS-1:0] cont,
    output logic                    busy,
    output logic                    done
);

    localparam int W    = DIGIT_W * DIGITS;
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    timer_state_t    state, next_state;
    logic [PS_W-1:0] presc;
    logic [W-1:0]    sat_val;
    logic [W-1:0]    digit_val;
    logic            digit_ld;
    logic [DIGITS:0] borrow;
    logic            run_tick;
    logic            dec_en;
    logic            terminal;
    logic            cont_zero;
    logic            reload_now;

    always_comb begin
        sat_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            sat_val[i*DIGIT_W +: DIGIT_W] = bcd_sat(load_val[i*DIGIT_W +: DIGIT_W]);
        end
    end

    assign run_tick  = (state == RUN) && !pause && (presc == PS_LAST);
    assign cont_zero = (cont == '0);
    assign terminal  = run_tick && (cont == W'(1));
    // A full borrow through every digit means the count is already zero; hold rather than wrap to all nines.
    assign dec_en    = run_tick && !borrow[DIGITS];
    assign borrow[0] = run_tick;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    logic [W-1:0] reload_val;
    logic         reload_hit;

    assign reload_now = terminal && (reload_val != '0);
    assign digit_ld   = load || reload_now;
    assign digit_val  = load ? sat_val : reload_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_val <= '0;
            reload_hit <= 1'b0;
        end else begin
            if (load) begin
                reload_val <= sat_val;
            end
            reload_hit <= reload_now && !load;
        end
    end
`else
    assign reload_now = 1'b0;
    assign digit_ld   = load;
    assign digit_val  = sat_val;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_down u_digit (
            .clk        (clk),
            .rst        (rst),
            .ld         (digit_ld),
            .ld_val     (digit_val[g*DIGIT_W +: DIGIT_W]),
            .dec_en     (dec_en),
            .borrow_in  (borrow[g]),
            .digit      (cont[g*DIGIT_W +: DIGIT_W]),
            .borrow_out (borrow[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || load || state != RUN) begin
            presc <= '0;
        end else if (!pause) begin
            presc <= run_tick ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (load) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && !cont_zero) next_state = RUN;
                RUN:     if (terminal && !reload_now) next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == RUN);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        done = (state == DONE) || reload_hit;
`else
        done = (state == DONE);
`endif
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed self-checking bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [7:0] cont;
    logic       busy;
    logic       done;
    logic [7:0] cont3;
    logic       busy3;
    logic       done3;

    int n_checks = 0;
    int n_errors = 0;

    bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .cont     (cont),
        .busy     (busy),
        .done     (done)
    );

    bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .cont     (cont3),
        .busy     (busy3),
        .done     (done3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        step();
        load     = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0;

        // reset overrides a simultaneous load
        rst = 1'b1; load = 1'b1; load_val = 8'h45;
        step();
        check("rst_cont", cont, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        step();
        rst = 1'b0; load = 1'b0;
        check("rst_cont2", cont, 8'h00);

`ifndef BCD_TIMER_AUTO_RELOAD_EN
        // full countdown from 12 including the 10 -> 09 borrow
        do_load(8'h12);
        check("cnt_load", cont, 8'h12);
        check("cnt_idle_busy", busy, 1'b0);
        do_start();
        check("cnt_run_busy", busy, 1'b1);
        check("cnt_run_first", cont, 8'h12);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("cnt_val_%0d", k), cont, bcd2(12 - k));
            check($sformatf("cnt_done_%0d", k), done, (k == 12) ? 1'b1 : 1'b0);
            check($sformatf("cnt_busy_%0d", k), busy, (k == 12) ? 1'b0 : 1'b1);
        end
        step();
        check("cnt_after_done", done, 1'b0);
        check("cnt_after_busy", busy, 1'b0);
        check("cnt_after_cont", cont, 8'h00);
`endif

        // saturation and ignored start at zero
        do_load(8'h3F);
        check("sat_3f", cont, 8'h39);
        do_load(8'hA7);
        check("sat_a7", cont, 8'h97);
        do_load(8'hFF);
        check("sat_ff", cont, 8'h99);
        do_load(8'h00);
        do_start();
        check("zero_start_busy", busy, 1'b0);
        check("zero_start_done", done, 1'b0);
        step();
        check("zero_start_busy2", busy, 1'b0);
        check("zero_start_done2", done, 1'b0);
        check("zero_start_cont", cont, 8'h00);

        // prescaler and pause on the TICK_DIV=3 instance
        do_load(8'h05);
        do_start();
        check("ps_busy", busy3, 1'b1);
        check("ps_e0", cont3, 8'h05);
        step(); check("ps_e1", cont3, 8'h05);
        step(); check("ps_e2", cont3, 8'h05);
        step(); check("ps_e3", cont3, 8'h04);
        step(); check("ps_e4", cont3, 8'h04);
        step(); check("ps_e5", cont3, 8'h04);
        step(); check("ps_e6", cont3, 8'h03);
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("pause_cont_%0d", k), cont3, 8'h03);
            check($sformatf("pause_busy_%0d", k), busy3, 1'b1);
        end
        pause = 1'b0;
        step(); check("resume_1", cont3, 8'h03);
        step(); check("resume_2", cont3, 8'h03);
        step(); check("resume_3", cont3, 8'h02);
        do_load(8'h00);
        check("ps_abort_busy", busy3, 1'b0);

        // synchronous reset in the middle of a run
        do_load(8'h09);
        do_start();
        step(); check("mid_8", cont, 8'h08);
        step(); check("mid_7", cont, 8'h07);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_cont", cont, 8'h00);
        check("mid_rst_busy", busy, 1'b0);

        // load aborts a run
        do_load(8'h17);
        do_start();
        step(); check("abort_16", cont, 8'h16);
        step(); check("abort_15", cont, 8'h15);
        do_load(8'h20);
        check("abort_cont", cont, 8'h20);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        step();
        check("abort_hold", cont, 8'h20);
        check("abort_done2", done, 1'b0);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
        do_load(8'h03);
        do_start();
        check("ar_start", cont, 8'h03);
        step(); check("ar_2", cont, 8'h02); check("ar_2_done", done, 1'b0);
        step(); check("ar_1", cont, 8'h01); check("ar_1_busy", busy, 1'b1);
        step(); check("ar_reload", cont, 8'h03); check("ar_reload_done", done, 1'b1);
        check("ar_reload_busy", busy, 1'b1);
        step(); check("ar_again", cont, 8'h02); check("ar_again_done", done, 1'b0);
        check("ar_again_busy", busy, 1'b1);
        do_load(8'h00);
        check("ar_stop_busy", busy, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Multi-digit BCD down-counter/timer: loads a decimal value, counts down to zero on prescaled ticks, flags completion.
- Counterpart of the mod-10 up counter (Cont_M10): same 4-bit-per-digit `cont` encoding, counting in the opposite direction.
- Used by SPRINT2+ designs for countdowns shown on 7-segment displays; its `cont` bus feeds the same display decoders as the up counter.

Parameters:
- DIGITS, 2, number of BCD digits; `cont` width is 4*DIGITS.
- TICK_DIV, 1, clk cycles per decrement while running (>=1); 1 means decrement every cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  load load_val (accepted in any state).
- load_val  in  4*DIGITS  BCD value to load; nibble [3:0] is units.
- start  in  1  start/resume countdown from IDLE.
- pause  in  1  level; holds count and prescaler while high in RUN.
- cont  out  4*DIGITS  current BCD count.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the count reaches zero.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset: cont=0, state=IDLE, prescaler=0, busy=0, done=0. Reset overrides every other input on that edge.
- States: IDLE, RUN, DONE, encoded in a package enum.
- Priority on each edge: rst > load > start > pause > tick.
- load, any state:
  - cont <= load_val, with every nibble >9 saturated to 9.
  - state -> IDLE, prescaler cleared, done=0.
  - load during RUN aborts the countdown.
- IDLE:
  - start with cont!=0 -> RUN, prescaler cleared.
  - start with cont==0 is ignored: stay IDLE, no done pulse.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; a tick occurs when prescaler==TICK_DIV-1, then prescaler wraps to 0.
  - The first decrement happens TICK_DIV cycles after the edge that entered RUN.
  - On a tick the units digit decrements. A digit at 0 wraps to 9 and issues a borrow to the next digit. A digit decrements only when every lower digit issues a borrow.
  - On the tick where cont==1 (value one), cont becomes 0 and state -> DONE on the same edge.
  - While pause=1, cont and prescaler hold and busy stays 1.
  - start while in RUN has no effect.
- DONE:
  - Lasts exactly one cycle; done=1 and cont=0 in that cycle.
  - Next state IDLE, unless load (load wins).
- busy=1 iff state==RUN. done=1 iff state==DONE.
- Arithmetic: per-digit mod-10 only. No binary subtraction across the full bus. Underflow below 0 cannot occur.

Optional Feature:
- Macro: BCD_TIMER_AUTO_RELOAD_EN.
- Defined:
  - An internal reload register captures each saturated load_val on load. Reset clears it to 0.
  - On the terminal tick, done still pulses for one cycle. cont is written with the reload value instead of 0, and the state stays RUN (no DONE state).
  - If the reload value is 0, behaviour falls back to normal DONE -> IDLE.
- Not defined:
  - No reload register.
  - Behaviour exactly as described above.

Decomposition:
- Package bcd_timer_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t.
  - localparam DIGIT_W=4, BCD_MAX=4'd9.
  - Function bcd_sat(nibble) implementing the saturate-to-9 rule.
- Sub-module bcd_digit_down, one instance per digit via generate:
  - Inputs: clk, rst, ld, ld_val[3:0], dec_en, borrow_in.
  - Outputs: digit[3:0], borrow_out (digit==0 && borrow_in).
  - Decrements with 0->9 wrap when dec_en && borrow_in. Units digit has borrow_in = tick.

Test Plan (DIGITS=2, TICK_DIV=1 unless noted):
1. Reset: rst=1 for 2 cycles with load=1, load_val=0x45 -> cont=0x00, busy=0, done=0 after first edge.
2. Countdown: load 0x12, then start:
   - cont goes 0x11, 0x10, 0x09 (borrow), ..., 0x01, 0x00 over 12 cycles.
   - done=1 exactly in the cycle cont=0x00; busy=0 and IDLE the next cycle.
3. Saturation and ignored start: load_val=0x3F -> cont=0x39. Load 0x00 then start -> busy stays 0, done never pulses.
4. Pause and prescaler (TICK_DIV=3):
   - Load 0x05, start -> one decrement every 3 cycles.
   - pause=1 for 4 cycles at cont=0x03 -> cont holds 0x03 and busy=1. Resumes 3 cycles after pause falls.
5. Mid-operation reset/load:
   - rst=1 at cont=0x07 in RUN -> next edge cont=0x00, IDLE.
   - load 0x20 at cont=0x15 in RUN -> cont=0x20, busy=0, no done.
6. BCD_TIMER_AUTO_RELOAD_EN defined: load 0x03, start -> cont 0x02, 0x01, 0x03 (done=1 that cycle), 0x02, ...; busy stays 1 throughout.
